layer_output_serializer: RTL

Parallel-to-serial bridge between two network layers. It collects the per-neuron outputs of a layer (NEURONS_NUM valid pulses plus a packed data bus) into a full frame. It then streams the frame one word per cycle, neuron 0 first, on the single-word data/valid interface that the next layer's neurons consume. Each neuron's valid pulse may arrive in a different cycle. A second frame can complete while the current one is still being shifted out.

---
 rtl/layer_output_serializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/layer_output_serializer.sv
// Collects per-neuron outputs into a frame, then streams it one word per cycle, neuron 0 first.
// Latency: completion in cycle T gives word 0 in T+1 and the last word in T+NEURONS_NUM.
// No backpressure: one frame may wait in the hold buffer; pulses arriving while it waits are dropped and flagged.
module layer_output_serializer #(
    parameter int NEURONS_NUM = 10,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NEURONS_NUM-1:0]            i_data_in_valid,
    input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data_in,
    output logic                              o_data_out_valid,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_frame_last,
    output logic                              o_busy,
    output logic                              o_overflow,
    output logic                              o_dup_error
);

    localparam int CW = (NEURONS_NUM > 1) ? $clog2(NEURONS_NUM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NEURONS_NUM - 1);

    typedef logic [NEURONS_NUM-1:0][DATA_WIDTH-1:0] frame_t;
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NEURONS_NUM-1:0] got_q, got_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   dup_q, dup_d;
    frame_t                 hold_q, hold_d;
    frame_t                 shift_q, shift_d;

    frame_t in_frame;
    frame_t merged;
    logic   complete;
    logic   at_last;
    logic   shifter_free;

    assign in_frame = i_data_in;

    // Merge this cycle's pulses over what has been collected so far.
    always_comb begin
        merged = hold_q;
        for (int k = 0; k < NEURONS_NUM; k++) begin
            if (i_data_in_valid[k]) begin
                merged[k] = in_frame[k];
            end
        end
    end

    assign complete     = !pending_q && (&(got_q | i_data_in_valid));
    assign at_last      = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
    assign shifter_free = (state_q == S_IDLE) || at_last;

    // Next-state logic: collection, pending hand-off and shifter FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        got_d      = got_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        dup_d      = dup_q;
        hold_d     = hold_q;
        shift_d    = shift_q;

        // Collection while the hold buffer is open; locked while a frame waits.
        if (!pending_q) begin
            hold_d = merged;
            got_d  = got_q | i_data_in_valid;
            if (|(got_q & i_data_in_valid)) begin
                dup_d = 1'b1;
            end
        end else if (|i_data_in_valid) begin
            overflow_d = 1'b1;
        end

        // Shifter advance; a waiting frame follows the last word without a bubble.
        if (state_q == S_SHIFT) begin
            if (!at_last) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pending_q) begin
                shift_d   = hold_q;
                pending_d = 1'b0;
                cnt_d     = '0;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end

        // Completed frame goes straight to the shifter if it is free, else waits in hold.
        if (complete) begin
            got_d = '0;
            if (shifter_free) begin
                shift_d = merged;
                state_d = S_SHIFT;
                cnt_d   = '0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial or in-flight frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            got_q      <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            dup_q      <= 1'b0;
            hold_q     <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            got_q      <= got_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            dup_q      <= dup_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
        end
    end

    // Output words come from the registered shift buffer; zero whenever not valid.
    always_comb begin
        o_data_out_valid = (state_q == S_SHIFT);
        o_data_out       = '0;
        o_frame_last     = 1'b0;
        if (state_q == S_SHIFT) begin
            o_data_out   = shift_q[cnt_q];
            o_frame_last = (cnt_q == LAST_IDX);
        end
    end

    assign o_busy      = (state_q == S_SHIFT) || pending_q;
    assign o_overflow  = overflow_q;
    assign o_dup_error = dup_q;

endmodule
